// File: rtl/rpn_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : rpn_engine_if
// Brief    : Command handshake bundle between the command decoder and the
//            RPN engine (valid/ready plus opcode and immediate).
// Revision : 1.0 - initial release
// ============================================================================
interface rpn_engine_if #(
    parameter int IN_W = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_op;
    logic [IN_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/rpn_engine.sv
`default_nettype none
// ============================================================================
// Module   : rpn_engine
// Brief    : RPN calculator engine. Top two entries live in registers, deeper
//            entries in a synchronous-read RAM; iterative mul/div/mod; sticky
//            error flag; valid/ready command handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rpn_engine #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int IN_W  = 8,
    parameter int SW    = $clog2(DEPTH+1)
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    rpn_engine_if.slave     cmd,
    output logic [WIDTH-1:0] top,
    output logic [SW-1:0]    size,
    output logic             empty,
    output logic             error,
    output logic             done
);
    localparam logic [3:0] c_OP_PUSH   = 4'd0;
    localparam logic [3:0] c_OP_APPEND = 4'd1;
    localparam logic [3:0] c_OP_POP    = 4'd2;
    localparam logic [3:0] c_OP_ADD    = 4'd3;
    localparam logic [3:0] c_OP_SUB    = 4'd4;
    localparam logic [3:0] c_OP_MUL    = 4'd5;
    localparam logic [3:0] c_OP_DIV    = 4'd6;
    localparam logic [3:0] c_OP_MOD    = 4'd7;
    localparam logic [3:0] c_OP_SWAP   = 4'd8;
    localparam logic [3:0] c_OP_DUP    = 4'd9;
    localparam logic [3:0] c_OP_CLEAR  = 4'd10;
    localparam int c_RAM_N = (DEPTH > 2) ? DEPTH - 2 : 1;
    localparam int c_AW    = (DEPTH > 3) ? $clog2(DEPTH - 2) : 1;
    localparam int c_CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_MULDIV = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_top, r_next, r_res, r_x, r_y, r_z;
    logic [SW-1:0]     r_size;
    logic              r_error, r_done;
    logic [3:0]        r_op;
    logic [c_CW-1:0]   r_cnt;

    logic [WIDTH-1:0]  w_top_nxt, w_next_nxt, w_res_nxt, w_x_nxt, w_y_nxt, w_z_nxt;
    logic [SW-1:0]     w_size_nxt;
    logic              w_error_nxt, w_done_nxt;
    logic [3:0]        w_op_nxt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic              w_accept, w_cmd_err, w_deep, w_reduce, w_wr_en, w_rd_en;
    logic [WIDTH-1:0]  w_red_val, w_alu, w_third;
    logic [c_AW-1:0]   w_wr_addr, w_rd_addr;
    logic [WIDTH:0]    w_t;
    logic              w_ge;
    logic [WIDTH-1:0]  w_x_it, w_y_it, w_z_it, w_md_res;

    assign w_accept      = cmd.cmd_valid && (r_state == S_IDLE);
    assign cmd.cmd_ready = (r_state == S_IDLE);
    // A depth-reducing op leaves more than two entries: the delivery takes an extra cycle.
    assign w_deep        = (r_size > SW'(3));
    assign top           = r_top;
    assign size          = r_size;
    assign empty         = (r_size == '0);
    assign error         = r_error;
    assign done          = r_done;

    // Error detection on the incoming command against the current stack state.
    always_comb begin
        w_cmd_err = 1'b0;
        case (cmd.cmd_op)
            c_OP_PUSH:                     w_cmd_err = (r_size == SW'(DEPTH));
            c_OP_APPEND, c_OP_POP:         w_cmd_err = (r_size == '0);
            c_OP_DUP:                      w_cmd_err = (r_size == '0) || (r_size == SW'(DEPTH));
            c_OP_ADD, c_OP_SUB, c_OP_MUL,
            c_OP_SWAP:                     w_cmd_err = (r_size < SW'(2));
            c_OP_DIV, c_OP_MOD:            w_cmd_err = (r_size < SW'(2)) || (r_top == '0);
            c_OP_CLEAR:                    w_cmd_err = 1'b0;
            default:                       w_cmd_err = 1'b1;
        endcase
    end

    // Single-cycle ALU result for POP/ADD/SUB (a = next, b = top).
    always_comb begin
        w_alu = r_next - r_top;
        if (cmd.cmd_op == c_OP_POP)      w_alu = r_next;
        else if (cmd.cmd_op == c_OP_ADD) w_alu = r_next + r_top;
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        w_t  = {r_z, r_y[WIDTH-1]};
        w_ge = (w_t >= {1'b0, r_x});
        if (r_op == c_OP_MUL) begin
            w_x_it = r_x << 1;
            w_y_it = r_y >> 1;
            w_z_it = r_z + (r_y[0] ? r_x : '0);
        end else begin
            w_x_it = r_x;
            w_y_it = {r_y[WIDTH-2:0], w_ge};
            w_z_it = w_ge ? WIDTH'(w_t - {1'b0, r_x}) : WIDTH'(w_t);
        end
        w_md_res = (r_op == c_OP_DIV) ? w_y_it : w_z_it;
    end

    // FSM next-state: idle, iterative mul/div, and the refill delivery cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_cmd_err) begin
                    if (cmd.cmd_op == c_OP_MUL || cmd.cmd_op == c_OP_DIV || cmd.cmd_op == c_OP_MOD)
                        w_state_nxt = S_MULDIV;
                    else if ((cmd.cmd_op == c_OP_POP || cmd.cmd_op == c_OP_ADD ||
                              cmd.cmd_op == c_OP_SUB) && w_deep)
                        w_state_nxt = S_REFILL;
                end
            end
            S_MULDIV: if (r_cnt == c_CW'(1)) w_state_nxt = w_deep ? S_REFILL : S_IDLE;
            S_REFILL: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath next-state: stack registers, RAM spill, sticky error, done pulse.
    always_comb begin
        w_top_nxt   = r_top;
        w_next_nxt  = r_next;
        w_size_nxt  = r_size;
        w_error_nxt = r_error;
        w_done_nxt  = 1'b0;
        w_op_nxt    = r_op;
        w_res_nxt   = r_res;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_z_nxt     = r_z;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_reduce    = 1'b0;
        w_red_val   = r_res;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt = cmd.cmd_op;
                    if (w_cmd_err) begin
                        w_error_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        case (cmd.cmd_op)
                            c_OP_PUSH, c_OP_DUP: begin
                                w_wr_en    = (r_size >= SW'(2));
                                w_next_nxt = r_top;
                                if (cmd.cmd_op == c_OP_PUSH) w_top_nxt = WIDTH'(cmd.cmd_data);
                                w_size_nxt = r_size + SW'(1);
                                w_done_nxt = 1'b1;
                            end
                            c_OP_APPEND: begin
                                w_top_nxt  = {r_top[WIDTH-IN_W-1:0], cmd.cmd_data};
                                w_done_nxt = 1'b1;
                            end
                            c_OP_POP, c_OP_ADD, c_OP_SUB: begin
                                w_red_val = w_alu;
                                w_res_nxt = w_alu;
                                w_reduce  = !w_deep;
                            end
                            c_OP_MUL, c_OP_DIV, c_OP_MOD: begin
                                w_x_nxt   = r_top;
                                w_y_nxt   = r_next;
                                w_z_nxt   = '0;
                                w_cnt_nxt = c_CW'(WIDTH);
                                if (cmd.cmd_op == c_OP_MUL) begin
                                    w_x_nxt = r_next;
                                    w_y_nxt = r_top;
                                end
                            end
                            c_OP_SWAP: begin
                                w_top_nxt  = r_next;
                                w_next_nxt = r_top;
                                w_done_nxt = 1'b1;
                            end
                            c_OP_CLEAR: begin
                                w_top_nxt   = '0;
                                w_size_nxt  = '0;
                                w_error_nxt = 1'b0;
                                w_done_nxt  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_MULDIV: begin
                w_x_nxt   = w_x_it;
                w_y_nxt   = w_y_it;
                w_z_nxt   = w_z_it;
                w_cnt_nxt = r_cnt - c_CW'(1);
                if (r_cnt == c_CW'(1)) begin
                    w_red_val = w_md_res;
                    w_res_nxt = w_md_res;
                    w_reduce  = !w_deep;
                end
            end
            S_REFILL: w_reduce = 1'b1;
            default: ;
        endcase
        // Retire a depth-reducing op: the third entry moves up into next.
        if (w_reduce) begin
            w_top_nxt  = (r_size == SW'(1)) ? '0 : w_red_val;
            w_next_nxt = w_third;
            w_size_nxt = r_size - SW'(1);
            w_done_nxt = 1'b1;
        end
    end

    // RAM holds entry k at address (size - k); read register tracks entry 3.
    assign w_wr_addr = c_AW'(r_size - SW'(2));
    assign w_rd_addr = c_AW'(w_size_nxt - SW'(3));
    assign w_rd_en   = (w_size_nxt >= SW'(3));

    generate
        if (DEPTH > 2) begin : g_ram
            logic [WIDTH-1:0] r_mem [c_RAM_N];
            logic [WIDTH-1:0] r_third;

            // Spill the old second entry when the stack grows past two.
            always_ff @(posedge clk) begin
                if (w_wr_en) r_mem[w_wr_addr] <= r_next;
            end

            // Look-ahead read of the next third entry, with write bypass on growth.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)                                r_third <= '0;
                else if (w_wr_en && (w_wr_addr == w_rd_addr)) r_third <= r_next;
                else if (w_rd_en)                            r_third <= r_mem[w_rd_addr];
            end
            assign w_third = r_third;
        end else begin : g_no_ram
            assign w_third = '0;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Stack, arithmetic and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top   <= '0;
            r_next  <= '0;
            r_size  <= '0;
            r_error <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_res   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
        end else begin
            r_top   <= w_top_nxt;
            r_next  <= w_next_nxt;
            r_size  <= w_size_nxt;
            r_error <= w_error_nxt;
            r_done  <= w_done_nxt;
            r_op    <= w_op_nxt;
            r_res   <= w_res_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_z     <= w_z_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rpn_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpn_engine
// Brief    : Self-checking bench for rpn_engine: queue-based reference stack,
//            scoreboard of expected retirements, independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpn_engine;
    localparam int WIDTH = 32;
    localparam int DEPTH = 6;
    localparam int IN_W  = 8;
    localparam int SW    = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    rpn_engine_if #(.IN_W(IN_W)) bus();
    logic [WIDTH-1:0] top;
    logic [SW-1:0]    size;
    logic             empty, error, done;

    rpn_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IN_W(IN_W)) dut (
        .clk(clk), .reset_n(reset_n), .cmd(bus),
        .top(top), .size(size), .empty(empty), .error(error), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] top;
        int               size;
        logic             err;
        int               acc;
        int               due;
    } exp_t;
    exp_t sb[$];

    logic [WIDTH-1:0] stk[$];
    logic             m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference stack: applies one accepted command, returns its latency.
    function automatic int model(input logic [3:0] op, input logic [IN_W-1:0] d);
        int n = stk.size();
        int lat = 1;
        bit bad = 0;
        logic [WIDTH-1:0] a, b, r;
        case (op)
            4'd0: if (n == DEPTH) bad = 1; else stk.push_back(WIDTH'(d));
            4'd1: if (n == 0) bad = 1; else stk[n-1] = (stk[n-1] << IN_W) | WIDTH'(d);
            4'd2: if (n == 0) bad = 1;
                  else begin void'(stk.pop_back()); lat = (n - 1 > 2) ? 2 : 1; end
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                if (n < 2 || (op >= 4'd6 && stk[n-1] == 0)) bad = 1;
                else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    case (op)
                        4'd3:    r = a + b;
                        4'd4:    r = a - b;
                        4'd5:    r = a * b;
                        4'd6:    r = a / b;
                        default: r = a % b;
                    endcase
                    stk.push_back(r);
                    lat = ((op >= 4'd5) ? WIDTH + 1 : 1) + ((n - 1 > 2) ? 1 : 0);
                end
            end
            4'd8: if (n < 2) bad = 1;
                  else begin a = stk[n-2]; stk[n-2] = stk[n-1]; stk[n-1] = a; end
            4'd9: if (n == 0 || n == DEPTH) bad = 1; else stk.push_back(stk[n-1]);
            4'd10: begin stk.delete(); m_err = 1'b0; end
            default: bad = 1;
        endcase
        if (bad) m_err = 1'b1;
        return lat;
    endfunction

    // Present a command from a falling edge; record expectation when accepted.
    task automatic issue(input logic [3:0] op, input logic [IN_W-1:0] d);
        int guard = 0;
        int lat;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        while (!bus.cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            fail_now("ready_timeout");
        end else begin
            lat    = model(op, d);
            e.top  = (stk.size() > 0) ? stk[$] : '0;
            e.size = stk.size();
            e.err  = m_err;
            e.acc  = cyc;
            e.due  = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_top"}, top, 0);
        chk({tag, "_size"}, size, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ready"}, bus.cmd_ready, 1);
    endtask

    // Monitor: compares every retirement against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (sb.size() > 0 && cyc > sb[0].acc && cyc < sb[0].due) begin
                    chk("ready_low_busy", bus.cmd_ready, 0);
                    chk("done_low_busy", done, 0);
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = sb.pop_front();
                        chk("latency", cyc - e.acc, e.due - e.acc);
                        chk("top", top, e.top);
                        chk("size", size, e.size);
                        chk("error", error, e.err);
                        chk("empty", empty, e.size == 0);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].due) begin
                    fail_now("done_missing");
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Immediate entry and appending.
        issue(4'd0, 8'h12); issue(4'd1, 8'h34); issue(4'd1, 8'h56);
        issue(4'd10, 8'h00);
        // Subtraction order and wrap-around.
        issue(4'd0, 8'd7); issue(4'd0, 8'd3); issue(4'd4, 8'h00);
        issue(4'd0, 8'd3); issue(4'd0, 8'd7); issue(4'd4, 8'h00);
        issue(4'd10, 8'h00);
        // Divide with three entries, then modulo by zero.
        issue(4'd0, 8'd1); issue(4'd0, 8'd100); issue(4'd0, 8'd7); issue(4'd6, 8'h00);
        issue(4'd0, 8'd0); issue(4'd7, 8'h00);
        issue(4'd10, 8'h00);
        // Overflow at full depth, then clear.
        for (int i = 0; i < DEPTH; i++) issue(4'd0, 8'(i + 1));
        issue(4'd0, 8'hEE); issue(4'd9, 8'h00);
        issue(4'd3, 8'h00); issue(4'd5, 8'h00); issue(4'd2, 8'h00);
        issue(4'd10, 8'h00);
        // Empty-stack errors, illegal opcode, stickiness across valid PUSH.
        issue(4'd2, 8'h00); issue(4'd8, 8'h00); issue(4'd13, 8'h00);
        issue(4'd0, 8'd5); issue(4'd10, 8'h00);

        // Randomized command stream.
        repeat (400) begin
            r = $urandom_range(0, 99);
            if      (r < 30) issue(4'd0, 8'($urandom));
            else if (r < 38) issue(4'd1, 8'($urandom));
            else if (r < 46) issue(4'd2, 8'h00);
            else if (r < 54) issue(4'd3, 8'h00);
            else if (r < 62) issue(4'd4, 8'h00);
            else if (r < 68) issue(4'd5, 8'h00);
            else if (r < 74) issue(4'd6, 8'h00);
            else if (r < 79) issue(4'd7, 8'h00);
            else if (r < 85) issue(4'd8, 8'h00);
            else if (r < 92) issue(4'd9, 8'h00);
            else if (r < 95) issue(4'd10, 8'h00);
            else             issue(4'($urandom_range(11, 15)), 8'h00);
        end
        drain();

        // Reset in the middle of a multiply.
        issue(4'd10, 8'h00); issue(4'd0, 8'd9); issue(4'd0, 8'd9);
        issue(4'd5, 8'h00);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        stk.delete();
        m_err = 1'b0;
        @(negedge clk);
        check_reset_values("midop_reset");
        reset_n = 1'b1;
        @(negedge clk);
        issue(4'd0, 8'hA5); issue(4'd9, 8'h00); issue(4'd3, 8'h00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
